ptp_bridge_igr_wrr_sched: RTL and testbench

//  Packet-granular weighted round-robin scheduler for the PTP bridge ingress arbiter.

---
 rtl/ptp_bridge_igr_wrr_sched.sv | 161 ++++++++++++++++
 tb/tb_ptp_bridge_igr_wrr_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptp_bridge_igr_wrr_sched.sv
// Packet-granular weighted round-robin scheduler for the PTP bridge ingress arbiter.
// Each ingress port may send up to wgt[i] packets per round; a grant is held from
// acceptance until end-of-packet so packets never interleave on the egress datapath.
// Optionally port 0 (PTP event traffic) wins every selection point outright.
module ptp_bridge_igr_wrr_sched #(
  parameter int N       = 4,
  parameter int WGT_W   = 4,
  parameter bit SP_IF0  = 1'b0,
  parameter int N_WIDTH = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WGT_W-1:0]   wgt,
  input  logic                 gnt_rdy,
  input  logic                 eop_done,
  output logic [N_WIDTH-1:0]   gnt,
  output logic                 gnt_vld,
  output logic                 busy,
  output logic [N*WGT_W-1:0]   credit
);

  typedef enum logic [1:0] {IDLE, REFILL, GRANT, XFER} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [N_WIDTH-1:0]   rr_ptr;
  logic [N_WIDTH-1:0]   rr_nxt;
  logic [N_WIDTH-1:0]   gnt_nxt;
  logic [N_WIDTH-1:0]   sel;
  logic [N_WIDTH-1:0]   gnt_inc;
  logic                 gnt_vld_nxt;
  logic                 busy_nxt;
  logic                 sp_gnt;
  logic                 sp_gnt_nxt;
  logic                 found;
  logic                 sp_win;
  logic                 needs_refill;
  logic                 accept;
  logic [N*WGT_W-1:0]   credit_nxt;
  logic [N-1:0]         wgt_nz;
  logic [N-1:0]         cred_nz;
  logic [N-1:0]         eligible;
  logic [WGT_W-1:0]     gnt_credit;
  logic [WGT_W-1:0]     gnt_credit_dec;
  int                   scan_idx;

  // Per-port qualification: a port competes only with a request, a nonzero weight and credit left
  always_comb begin
    wgt_nz  = '0;
    cred_nz = '0;
    for (int i = 0; i < N; i++) begin
      wgt_nz[i]  = |wgt[i*WGT_W +: WGT_W];
      cred_nz[i] = |credit[i*WGT_W +: WGT_W];
    end
    eligible     = req & wgt_nz & cred_nz;
    needs_refill = (|(req & wgt_nz)) & ~(|eligible);
    sp_win       = SP_IF0 && req[0] && wgt_nz[0];
  end

  // Rotating search from rr_ptr; strict-priority port 0 pre-empts the search entirely
  always_comb begin
    found    = sp_win;
    sel      = '0;
    scan_idx = 0;
    if (!sp_win) begin
      for (int k = 0; k < N; k++) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= N) scan_idx = scan_idx - N;
        if (!found && eligible[scan_idx]) begin
          found = 1'b1;
          sel   = N_WIDTH'(scan_idx);
        end
      end
    end
  end

  // Credit of the granted port after a saturating decrement, and the wrapped successor index
  always_comb begin
    gnt_credit     = credit[int'(gnt)*WGT_W +: WGT_W];
    gnt_credit_dec = (gnt_credit == '0) ? '0 : gnt_credit - WGT_W'(1);
    gnt_inc        = (gnt == N_WIDTH'(N-1)) ? '0 : gnt + N_WIDTH'(1);
    accept         = (state == GRANT) && gnt_vld && gnt_rdy;
  end

  // Next-state and next-output logic for the IDLE/REFILL/GRANT/XFER machine
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_vld_nxt = gnt_vld;
    busy_nxt    = busy;
    credit_nxt  = credit;
    rr_nxt      = rr_ptr;
    sp_gnt_nxt  = sp_gnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt   = GRANT;
          gnt_nxt     = sel;
          gnt_vld_nxt = 1'b1;
          sp_gnt_nxt  = sp_win;
        end else if (needs_refill) begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        credit_nxt = wgt;
        state_nxt  = IDLE;
      end
      GRANT: begin
        if (accept) begin
          gnt_vld_nxt = 1'b0;
          if (!sp_gnt) begin
            credit_nxt[int'(gnt)*WGT_W +: WGT_W] = gnt_credit_dec;
            rr_nxt = (gnt_credit_dec != '0) ? gnt : gnt_inc;
          end
          if (eop_done) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = XFER;
            busy_nxt  = 1'b1;
          end
        end
      end
      XFER: begin
        if (eop_done) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; an in-flight packet is simply dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      busy    <= 1'b0;
      credit  <= '0;
      rr_ptr  <= '0;
      sp_gnt  <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_vld <= gnt_vld_nxt;
      busy    <= busy_nxt;
      credit  <= credit_nxt;
      rr_ptr  <= rr_nxt;
      sp_gnt  <= sp_gnt_nxt;
    end
  end

  // The granted port must keep its request up while its grant is on offer
  a_req_held: assert property (@(posedge clk) disable iff (rst) (state == GRANT) |-> req[gnt]);

endmodule

// File: tb/tb_ptp_bridge_igr_wrr_sched.sv
// Self-checking bench for ptp_bridge_igr_wrr_sched: a cycle vector table plus
// hand-written sequences for weighted rounds, back-pressure, reset and strict priority.
module tb_ptp_bridge_igr_wrr_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  req = '0;
  logic [15:0] wgt = '0;
  logic        gnt_rdy = 1'b0;
  logic        eop_done = 1'b0;
  logic [1:0]  gnt;
  logic        gnt_vld;
  logic        busy;
  logic [15:0] credit;

  logic [3:0]  req_s = '0;
  logic [15:0] wgt_s = '0;
  logic        gnt_rdy_s = 1'b0;
  logic        eop_done_s = 1'b0;
  logic [1:0]  gnt_s;
  logic        gnt_vld_s;
  logic        busy_s;
  logic [15:0] credit_s;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] wgt;
    logic        rdy;
    logic        eop;
    logic [1:0]  e_gnt;
    logic        e_vld;
    logic        e_busy;
    logic [15:0] e_credit;
  } vec_t;

  vec_t vecs[$];

  ptp_bridge_igr_wrr_sched #(.N(4), .WGT_W(4), .SP_IF0(1'b0)) dut (
    .clk(clk), .rst(rst), .req(req), .wgt(wgt), .gnt_rdy(gnt_rdy), .eop_done(eop_done),
    .gnt(gnt), .gnt_vld(gnt_vld), .busy(busy), .credit(credit)
  );

  ptp_bridge_igr_wrr_sched #(.N(4), .WGT_W(4), .SP_IF0(1'b1)) dut_sp (
    .clk(clk), .rst(rst), .req(req_s), .wgt(wgt_s), .gnt_rdy(gnt_rdy_s), .eop_done(eop_done_s),
    .gnt(gnt_s), .gnt_vld(gnt_vld_s), .busy(busy_s), .credit(credit_s)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case something never settles
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] w, input logic rdy, input logic eop);
    req      = r;
    wgt      = w;
    gnt_rdy  = rdy;
    eop_done = eop;
    tick();
  endtask

  task automatic add_vec(input logic [3:0] r, input logic [15:0] w, input logic rdy, input logic eop,
                         input logic [1:0] eg, input logic ev, input logic eb, input logic [15:0] ec);
    vec_t v;
    v.req = r; v.wgt = w; v.rdy = rdy; v.eop = eop;
    v.e_gnt = eg; v.e_vld = ev; v.e_busy = eb; v.e_credit = ec;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; wgt = '0; gnt_rdy = 1'b0; eop_done = 1'b0;
    req_s = '0; wgt_s = '0; gnt_rdy_s = 1'b0; eop_done_s = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a grant on the main DUT, check it, then accept it as a single-beat packet
  task automatic take_packet(input logic [1:0] exp_port, input logic [15:0] exp_cred, input string tag);
    int waited = 0;
    gnt_rdy  = 1'b0;
    eop_done = 1'b0;
    while (gnt_vld !== 1'b1 && waited < 6) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_vld"}, 32'(gnt_vld), 32'd1);
    checkOutput({tag, "_gnt"}, 32'(gnt), 32'(exp_port));
    gnt_rdy  = 1'b1;
    eop_done = 1'b1;
    tick();
    gnt_rdy  = 1'b0;
    eop_done = 1'b0;
    checkOutput({tag, "_cred"}, 32'(credit), 32'(exp_cred));
  endtask

  initial begin
    logic [1:0]  t2_port [7];
    logic [15:0] t2_cred [7];

    // Vector table: inputs for one cycle, registered outputs expected after that edge
    add_vec(4'hF, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
    add_vec(4'hF, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h1111);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 16'h1111);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h1110);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 16'h1110);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 16'h1110);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h1100);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 16'h1100);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 16'h1100);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'h1000);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 16'h1000);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 16'h0000);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 16'h0000);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 16'h1111);
    add_vec(4'hF, 16'h1111, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 16'h1111);

    t2_port = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    t2_cred = '{16'h1212, 16'h1211, 16'h1210, 16'h1200, 16'h1100, 16'h1000, 16'h0000};

    // Reset state
    do_reset();
    rst = 1'b1;
    tick();
    checkOutput("reset_main", 32'({gnt, gnt_vld, busy, credit}), 32'd0);
    checkOutput("reset_sp", 32'({gnt_s, gnt_vld_s, busy_s, credit_s}), 32'd0);
    rst = 1'b0;

    // Table: disabled ports, equal-weight rotation, multi-beat and single-beat packets, refill
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].wgt, vecs[i].rdy, vecs[i].eop);
      checkOutput($sformatf("vec%0d", i), 32'({gnt, gnt_vld, busy, credit}),
                  32'({vecs[i].e_gnt, vecs[i].e_vld, vecs[i].e_busy, vecs[i].e_credit}));
    end

    // Weighted rounds 3,1,2,1: two full rounds
    do_reset();
    req = 4'hF;
    wgt = 16'h1213;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 7; k++) begin
        take_packet(t2_port[k], t2_cred[k], $sformatf("wrr_r%0d_p%0d", r, k));
      end
    end

    // Back-pressure: grant to port 2 held stable with credit untouched
    do_reset();
    req = 4'b0100;
    wgt = 16'h1111;
    for (int w = 0; w < 6 && gnt_vld !== 1'b1; w++) tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput($sformatf("hold%0d", c), 32'({gnt_vld, gnt, credit}), 32'({1'b1, 2'd2, 16'h1111}));
    end
    gnt_rdy = 1'b1;
    tick();
    gnt_rdy = 1'b0;
    checkOutput("hold_accept", 32'({gnt_vld, busy, gnt, credit}), 32'({1'b0, 1'b1, 2'd2, 16'h1011}));
    tick();
    checkOutput("hold_xfer", 32'({gnt_vld, busy, gnt}), 32'({1'b0, 1'b1, 2'd2}));
    eop_done = 1'b1;
    tick();
    eop_done = 1'b0;
    req = 4'b0000;
    checkOutput("hold_eop", 32'({gnt_vld, busy}), 32'd0);

    // Reset in the middle of a transfer with credit[1]=2 left
    do_reset();
    req = 4'b0010;
    wgt = 16'h0030;
    for (int w = 0; w < 6 && gnt_vld !== 1'b1; w++) tick();
    checkOutput("rst_gnt", 32'({gnt_vld, gnt, credit}), 32'({1'b1, 2'd1, 16'h0030}));
    gnt_rdy = 1'b1;
    tick();
    gnt_rdy = 1'b0;
    checkOutput("rst_xfer", 32'({busy, credit}), 32'({1'b1, 16'h0020}));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid", 32'({gnt, gnt_vld, busy, credit}), 32'd0);
    tick();
    checkOutput("rst_refill_enter", 32'({gnt_vld, credit}), 32'd0);
    tick();
    checkOutput("rst_refill_done", 32'({gnt_vld, credit}), 32'({1'b0, 16'h0030}));
    tick();
    checkOutput("rst_regrant", 32'({gnt_vld, gnt}), 32'({1'b1, 2'd1}));
    gnt_rdy  = 1'b1;
    eop_done = 1'b1;
    tick();
    gnt_rdy  = 1'b0;
    eop_done = 1'b0;
    req      = 4'b0000;

    // Strict priority for port 0: port 3 finishes, port 0 next, round-robin pointer untouched
    do_reset();
    wgt_s = 16'h2111;
    req_s = 4'b0010;
    tick(); tick(); tick();
    checkOutput("sp_first", 32'({gnt_vld_s, gnt_s, credit_s}), 32'({1'b1, 2'd1, 16'h2111}));
    gnt_rdy_s = 1'b1; eop_done_s = 1'b1;
    tick();
    gnt_rdy_s = 1'b0; eop_done_s = 1'b0;
    checkOutput("sp_first_done", 32'({gnt_vld_s, credit_s}), 32'({1'b0, 16'h2101}));
    req_s = 4'b1000;
    tick();
    checkOutput("sp_p3_gnt", 32'({gnt_vld_s, gnt_s}), 32'({1'b1, 2'd3}));
    gnt_rdy_s = 1'b1;
    tick();
    gnt_rdy_s = 1'b0;
    checkOutput("sp_p3_xfer", 32'({busy_s, gnt_vld_s, credit_s}), 32'({1'b1, 1'b0, 16'h1101}));
    req_s = 4'b1101;
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput($sformatf("sp_p3_hold%0d", c), 32'({busy_s, gnt_vld_s, gnt_s}), 32'({1'b1, 1'b0, 2'd3}));
    end
    eop_done_s = 1'b1;
    tick();
    eop_done_s = 1'b0;
    checkOutput("sp_p3_eop", 32'({busy_s, gnt_vld_s}), 32'd0);
    tick();
    checkOutput("sp_p0_gnt", 32'({gnt_vld_s, gnt_s}), 32'({1'b1, 2'd0}));
    gnt_rdy_s = 1'b1; eop_done_s = 1'b1;
    tick();
    gnt_rdy_s = 1'b0; eop_done_s = 1'b0;
    checkOutput("sp_p0_credit", 32'(credit_s), 32'h1101);
    req_s = 4'b1100;
    tick();
    checkOutput("sp_rr_kept", 32'({gnt_vld_s, gnt_s}), 32'({1'b1, 2'd3}));
    gnt_rdy_s = 1'b1; eop_done_s = 1'b1;
    tick();
    gnt_rdy_s = 1'b0; eop_done_s = 1'b0;
    req_s = 4'b0000;
    checkOutput("sp_p3_credit", 32'(credit_s), 32'h0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
